segre_tlb_assoc: RTL and testbench
==================================

Name: segre_tlb_assoc

Overview:
Parametrised, fully-associative, single-cycle-registered TLB for the Segre cache subsystem, placed in front of the data/instruction cache tag lookup.
- Translates full virtual addresses to physical addresses and checks a per-entry R/W/X permission vector.
- Provides a valid/ready lookup handshake, duplicate-free fills with first-invalid/round-robin replacement, and whole-table or single-page invalidation.

Parameters:
NUM_ENTRIES, 4, TLB entries; power of two, >=2
VADDR_W, 32, virtual address width
PADDR_W, 20, physical address width
PAGE_OFFSET_W, 12, untranslated page-offset bits; VPN = VADDR_W-PAGE_OFFSET_W, PPN = PADDR_W-PAGE_OFFSET_W

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  lookup request
req_ready_o  out  1  lookup accepted this cycle
req_vaddr_i  in  VADDR_W  lookup virtual address
req_access_i  in  3  one-hot access {X,W,R}
rsp_valid_o  out  1  response valid, one-cycle pulse
rsp_hit_o  out  1  translation hit
rsp_miss_o  out  1  translation miss
rsp_pp_exc_o  out  1  page-protection exception
rsp_paddr_o  out  PADDR_W  translated address
fill_i  in  1  write entry
fill_vpn_i  in  VPN  fill virtual page number
fill_ppn_i  in  PPN  fill physical page number
fill_perm_i  in  3  fill permission {X,W,R}
inval_all_i  in  1  invalidate whole table
inval_page_i  in  1  invalidate entry matching inval_vpn_i
inval_vpn_i  in  VPN  page to invalidate

Behaviour:
- Reset (async, rst_i=1): all entries valid=0, VPN/PPN/perm=0, round-robin pointer=0. rsp_valid_o, rsp_hit_o, rsp_miss_o and rsp_pp_exc_o are 0; rsp_paddr_o is 0. No preloaded entries. Reset mid-lookup drops the pending response.
- req_ready_o = ~(fill_i | inval_all_i | inval_page_i), combinational. Table-update cycles block lookups, so a lookup and an update never occur in the same cycle.
- Lookup accepted on req_valid_i & req_ready_o in cycle N. Response registered and valid in N+1 only, with latency 1. Back-to-back accepts give back-to-back responses.
- Hit: some valid entry has VPN == req_vaddr_i[VADDR_W-1:PAGE_OFFSET_W].
  - rsp_paddr_o = {entry PPN, req_vaddr_i[PAGE_OFFSET_W-1:0]}.
  - rsp_pp_exc_o = ((perm & access) == 0) or access not one-hot.
  - A hit with an exception still reports rsp_hit_o=1, and rsp_paddr_o is 0.
- Miss: rsp_miss_o=1, rsp_hit_o=0, rsp_pp_exc_o=0, rsp_paddr_o=0.
- When rsp_valid_o=0, all rsp_* outputs are 0.
- Update priority in one cycle: inval_all_i > fill_i > inval_page_i. Lower-priority updates are dropped.
- inval_all_i: all valid=0 and pointer=0 next edge.
- inval_page_i: the matching valid entry gets valid=0; no match is a no-op. The pointer is unchanged.
- fill_i victim selection:
  1. Entry already holding fill_vpn_i, valid: overwrite in place, pointer unchanged.
  2. Else the lowest-index invalid entry, pointer unchanged.
  3. Else the entry at the pointer, then pointer+1 mod NUM_ENTRIES (wraps).
  - The written entry becomes valid.
- Invariant: at most one valid entry per VPN. Multi-hit is flagged by a simulation assertion. If it ever occurs, the lowest index wins.

Optional Feature:
Macro SEGRE_TLB_PERF_CNT_EN.
- Defined: adds ports perf_clr_i (in, 1), hit_cnt_o (out, 32) and miss_cnt_o (out, 32).
  - The counters increment at the edge that produces rsp_hit_o or rsp_miss_o respectively.
  - They saturate at 32'hFFFF_FFFF and reset to 0.
  - perf_clr_i zeroes both counters next edge and overrides an increment in the same cycle.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- segre_pkg: tlb_perm_t (3-bit packed {x,w,r}), constants TLB_ACC_R=3'b001, TLB_ACC_W=3'b010, TLB_ACC_X=3'b100.
- The tlb_entry_t struct stays local because it is parameter-dependent.
- One sub-module, segre_tlb_repl:
  - Inputs: valid vector, match vector, fill pulse, inval_all.
  - Output: victim index.
  - Holds the round-robin pointer and the first-invalid priority encoder.

Test Plan:
1. Reset, fill VPN 0x0000A/PPN 0x0A/perm R|W, lookup vaddr 0x0000A123 access R -> next cycle rsp_valid=1, hit=1, paddr=0x0A123, pp_exc=0.
2. Same entry, access X -> hit=1, pp_exc=1, paddr=0. Lookup 0x0000B000 -> miss=1, paddr=0.
3. NUM_ENTRIES=4: fill VPNs 1..4, then VPN 5 and 6 -> entries 0 and 1 replaced, pointer=2. Lookups of VPN 1 and 2 miss; VPN 3 and 5 hit.
4. Refill VPN 3 with PPN 0x33 -> in place, no new slot. inval_page VPN 3 -> VPN 3 misses; next fill VPN 7 lands in the freed index.
5. fill_i and inval_all_i in the same cycle with req_valid_i=1 -> req_ready_o=0, no response next cycle, table empty, next lookup misses.
6. SEGRE_TLB_PERF_CNT_EN: 3 hits, 2 misses -> hit_cnt=3, miss_cnt=2. perf_clr_i coinciding with a hit response -> both counters 0.

Source files
------------

// File: rtl/segre_pkg.sv
// Shared types and access encodings for the Segre cache-subsystem TLB.
package segre_pkg;

  localparam int unsigned TLB_ACC_BITS = 3;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } tlb_perm_t;

  localparam logic [TLB_ACC_BITS-1:0] TLB_ACC_R = 3'b001;
  localparam logic [TLB_ACC_BITS-1:0] TLB_ACC_W = 3'b010;
  localparam logic [TLB_ACC_BITS-1:0] TLB_ACC_X = 3'b100;

  // True when exactly one access-type bit is set.
  function automatic logic tlb_acc_onehot(input logic [TLB_ACC_BITS-1:0] acc);
    return (acc != 3'b000) && ((acc & (acc - 3'd1)) == 3'b000);
  endfunction

endpackage

// File: rtl/segre_tlb_repl.sv
// Fill victim selection for segre_tlb_assoc: in-place match, else first invalid,
// else round-robin pointer.
module segre_tlb_repl
  import segre_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic [NUM_ENTRIES-1:0] match_i,
  input  logic                   fill_i,
  input  logic                   inval_all_i,
  output logic [IDX_W-1:0]       victim_c_o
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_match_any;
  logic [IDX_W-1:0] w_match_idx;
  logic             w_free_any;
  logic [IDX_W-1:0] w_free_idx;

  // Lowest-index encoders for the in-place match and the first free slot.
  always_comb begin
    w_match_any = 1'b0;
    w_match_idx = '0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (match_i[i]) begin
        w_match_any = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!valid_i[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    victim_c_o = r_ptr;
    if (w_match_any) begin
      victim_c_o = w_match_idx;
    end else if (w_free_any) begin
      victim_c_o = w_free_idx;
    end
  end

  // Pointer only moves when a full table forces an eviction; power-of-two wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (inval_all_i) begin
      r_ptr <= '0;
    end else if (fill_i && !w_match_any && !w_free_any) begin
      r_ptr <= r_ptr + IDX_W'(1);
    end
  end

endmodule

// File: rtl/segre_tlb_assoc.sv
// Fully-associative TLB with registered lookup response and permission check.
// Optional hit/miss counters enabled by defining SEGRE_TLB_PERF_CNT_EN.
module segre_tlb_assoc
  import segre_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES   = 4,
  parameter int unsigned VADDR_W       = 32,
  parameter int unsigned PADDR_W       = 20,
  parameter int unsigned PAGE_OFFSET_W = 12
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [VADDR_W-1:0]                req_vaddr_i,
  input  logic [2:0]                        req_access_i,
  output logic                              rsp_valid_o,
  output logic                              rsp_hit_o,
  output logic                              rsp_miss_o,
  output logic                              rsp_pp_exc_o,
  output logic [PADDR_W-1:0]                rsp_paddr_o,
  input  logic                              fill_i,
  input  logic [VADDR_W-PAGE_OFFSET_W-1:0]  fill_vpn_i,
  input  logic [PADDR_W-PAGE_OFFSET_W-1:0]  fill_ppn_i,
  input  logic [2:0]                        fill_perm_i,
  input  logic                              inval_all_i,
  input  logic                              inval_page_i,
  input  logic [VADDR_W-PAGE_OFFSET_W-1:0]  inval_vpn_i
`ifdef SEGRE_TLB_PERF_CNT_EN
  ,
  input  logic                              perf_clr_i,
  output logic [31:0]                       hit_cnt_o,
  output logic [31:0]                       miss_cnt_o
`endif
);

  localparam int unsigned VPN_W = VADDR_W - PAGE_OFFSET_W;
  localparam int unsigned PPN_W = PADDR_W - PAGE_OFFSET_W;
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    tlb_perm_t        perm;
  } tlb_entry_t;

  tlb_entry_t r_tbl [NUM_ENTRIES];

  logic                     r_rsp_valid;
  logic                     r_rsp_hit;
  logic                     r_rsp_miss;
  logic                     r_rsp_pp_exc;
  logic [PADDR_W-1:0]       r_rsp_paddr;

  logic [VPN_W-1:0]         w_req_vpn;
  logic [PAGE_OFFSET_W-1:0] w_req_off;
  logic [NUM_ENTRIES-1:0]   w_valid;
  logic [NUM_ENTRIES-1:0]   w_req_match;
  logic [NUM_ENTRIES-1:0]   w_fill_match;
  logic [NUM_ENTRIES-1:0]   w_inval_match;
  logic                     w_hit;
  logic [PPN_W-1:0]         w_hit_ppn;
  logic [2:0]               w_hit_perm;
  logic                     w_exc;
  logic                     w_req_fire;
  logic                     w_fill_en;
  logic [IDX_W-1:0]         w_victim;

  assign req_ready_o = ~(fill_i | inval_all_i | inval_page_i);
  assign w_req_fire  = req_valid_i & req_ready_o;
  assign w_fill_en   = fill_i & ~inval_all_i;
  assign w_req_vpn   = req_vaddr_i[VADDR_W-1:PAGE_OFFSET_W];
  assign w_req_off   = req_vaddr_i[PAGE_OFFSET_W-1:0];

  always_comb begin
    w_valid       = '0;
    w_req_match   = '0;
    w_fill_match  = '0;
    w_inval_match = '0;
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      w_valid[i]       = r_tbl[i].valid;
      w_req_match[i]   = r_tbl[i].valid && (r_tbl[i].vpn == w_req_vpn);
      w_fill_match[i]  = r_tbl[i].valid && (r_tbl[i].vpn == fill_vpn_i);
      w_inval_match[i] = r_tbl[i].valid && (r_tbl[i].vpn == inval_vpn_i);
    end
  end

  // Lowest matching index wins should the one-entry-per-VPN invariant break.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_ppn  = '0;
    w_hit_perm = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (w_req_match[i]) begin
        w_hit      = 1'b1;
        w_hit_ppn  = r_tbl[i].ppn;
        w_hit_perm = r_tbl[i].perm;
      end
    end
  end

  assign w_exc = ((w_hit_perm & req_access_i) == 3'b000) || !tlb_acc_onehot(req_access_i);

  segre_tlb_repl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_repl (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (w_valid),
    .match_i     (w_fill_match),
    .fill_i      (w_fill_en),
    .inval_all_i (inval_all_i),
    .victim_c_o  (w_victim)
  );

  // Table updates: inval_all over fill over inval_page.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        r_tbl[i] <= '0;
      end
    end else if (inval_all_i) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        r_tbl[i].valid <= 1'b0;
      end
    end else if (fill_i) begin
      r_tbl[w_victim] <= '{valid: 1'b1, vpn: fill_vpn_i, ppn: fill_ppn_i, perm: fill_perm_i};
    end else if (inval_page_i) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        if (w_inval_match[i]) begin
          r_tbl[i].valid <= 1'b0;
        end
      end
    end
  end

  // Response is a one-cycle pulse; every field is zero outside it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_hit    <= 1'b0;
      r_rsp_miss   <= 1'b0;
      r_rsp_pp_exc <= 1'b0;
      r_rsp_paddr  <= '0;
    end else begin
      r_rsp_valid  <= w_req_fire;
      r_rsp_hit    <= w_req_fire & w_hit;
      r_rsp_miss   <= w_req_fire & ~w_hit;
      r_rsp_pp_exc <= w_req_fire & w_hit & w_exc;
      r_rsp_paddr  <= (w_req_fire && w_hit && !w_exc) ? {w_hit_ppn, w_req_off} : '0;
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_hit_o    = r_rsp_hit;
  assign rsp_miss_o   = r_rsp_miss;
  assign rsp_pp_exc_o = r_rsp_pp_exc;
  assign rsp_paddr_o  = r_rsp_paddr;

`ifdef SEGRE_TLB_PERF_CNT_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  // Saturating counters; clear beats a same-cycle increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (perf_clr_i) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_req_fire && w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
        r_hit_cnt <= r_hit_cnt + 32'd1;
      end
      if (w_req_fire && !w_hit && (r_miss_cnt != 32'hFFFF_FFFF)) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

  a_no_multi_hit: assert property (@(posedge clk_i) disable iff (rst_i)
    w_req_fire |-> $onehot0(w_req_match))
    else $error("segre_tlb_assoc: multiple entries match vpn %h", w_req_vpn);

endmodule

// File: tb/tb_segre_tlb_assoc.sv
// Directed self-checking bench for segre_tlb_assoc (default 4-entry configuration).
module tb_segre_tlb_assoc;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic [2:0]  req_access_i = 3'b001;
  logic        rsp_valid_o, rsp_hit_o, rsp_miss_o, rsp_pp_exc_o;
  logic [19:0] rsp_paddr_o;
  logic        fill_i = 1'b0;
  logic [19:0] fill_vpn_i = '0;
  logic [7:0]  fill_ppn_i = '0;
  logic [2:0]  fill_perm_i = '0;
  logic        inval_all_i = 1'b0;
  logic        inval_page_i = 1'b0;
  logic [19:0] inval_vpn_i = '0;
`ifdef SEGRE_TLB_PERF_CNT_EN
  logic        perf_clr_i = 1'b0;
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Response vector layout: {valid, hit, miss, pp_exc, paddr}
  localparam logic [3:0] HIT  = 4'b1100;
  localparam logic [3:0] MISS = 4'b1010;
  localparam logic [3:0] EXC  = 4'b1101;

  always #5 clk_i = ~clk_i;

  segre_tlb_assoc dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vaddr_i  (req_vaddr_i),
    .req_access_i (req_access_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_hit_o    (rsp_hit_o),
    .rsp_miss_o   (rsp_miss_o),
    .rsp_pp_exc_o (rsp_pp_exc_o),
    .rsp_paddr_o  (rsp_paddr_o),
    .fill_i       (fill_i),
    .fill_vpn_i   (fill_vpn_i),
    .fill_ppn_i   (fill_ppn_i),
    .fill_perm_i  (fill_perm_i),
    .inval_all_i  (inval_all_i),
    .inval_page_i (inval_page_i),
    .inval_vpn_i  (inval_vpn_i)
`ifdef SEGRE_TLB_PERF_CNT_EN
    ,
    .perf_clr_i   (perf_clr_i),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  function automatic logic [23:0] rsp_vec();
    return {rsp_valid_o, rsp_hit_o, rsp_miss_o, rsp_pp_exc_o, rsp_paddr_o};
  endfunction

  task automatic do_fill(input logic [19:0] vpn, input logic [7:0] ppn, input logic [2:0] perm);
    @(negedge clk_i);
    fill_i = 1'b1; fill_vpn_i = vpn; fill_ppn_i = ppn; fill_perm_i = perm;
    @(negedge clk_i);
    fill_i = 1'b0;
  endtask

  task automatic do_inval_page(input logic [19:0] vpn);
    @(negedge clk_i);
    inval_page_i = 1'b1; inval_vpn_i = vpn;
    @(negedge clk_i);
    inval_page_i = 1'b0;
  endtask

  task automatic do_inval_all();
    @(negedge clk_i);
    inval_all_i = 1'b1;
    @(negedge clk_i);
    inval_all_i = 1'b0;
  endtask

  // One accepted lookup; returns the response vector sampled one cycle later.
  task automatic do_lookup(input logic [31:0] va, input logic [2:0] acc, output logic [23:0] obs);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_vaddr_i = va; req_access_i = acc;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    obs = rsp_vec();
  endtask

  task automatic test_reset();
    logic [23:0] obs;
    #1;
    n_cmp++; if (rsp_vec() !== 24'h0) begin n_err++; $display("FAIL reset_rsp: got %h want %h", rsp_vec(), 24'h0); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    @(negedge clk_i); rst_i = 1'b0;
    // reset arriving while a lookup is in flight drops the response
    @(negedge clk_i);
    req_valid_i = 1'b1; req_vaddr_i = 32'h0000_0000; req_access_i = 3'b001;
    #2 rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; req_valid_i = 1'b0;
    obs = rsp_vec();
    n_cmp++; if (obs !== 24'h0) begin n_err++; $display("FAIL reset_mid_lookup: got %h want %h", obs, 24'h0); end
    do_lookup(32'h0000_0123, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL reset_empty_table: got %h want %h", obs, {MISS, 20'h0}); end
  endtask

  task automatic test_hit_perm();
    logic [23:0] obs;
    do_fill(20'h0000A, 8'h0A, 3'b011);
    do_lookup(32'h0000_A123, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h0A123}) begin n_err++; $display("FAIL hit_r: got %h want %h", obs, {HIT, 20'h0A123}); end
    do_lookup(32'h0000_A7FF, 3'b010, obs);
    n_cmp++; if (obs !== {HIT, 20'h0A7FF}) begin n_err++; $display("FAIL hit_w: got %h want %h", obs, {HIT, 20'h0A7FF}); end
    do_lookup(32'h0000_A123, 3'b100, obs);
    n_cmp++; if (obs !== {EXC, 20'h0}) begin n_err++; $display("FAIL exc_x: got %h want %h", obs, {EXC, 20'h0}); end
    do_lookup(32'h0000_A123, 3'b011, obs);
    n_cmp++; if (obs !== {EXC, 20'h0}) begin n_err++; $display("FAIL exc_not_onehot: got %h want %h", obs, {EXC, 20'h0}); end
    do_lookup(32'h0000_A123, 3'b000, obs);
    n_cmp++; if (obs !== {EXC, 20'h0}) begin n_err++; $display("FAIL exc_zero_acc: got %h want %h", obs, {EXC, 20'h0}); end
    do_lookup(32'h0000_B000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL miss_b: got %h want %h", obs, {MISS, 20'h0}); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] obs;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_vaddr_i = 32'h0000_A456; req_access_i = 3'b001;
    @(negedge clk_i);
    obs = rsp_vec();
    req_vaddr_i = 32'h0000_B000;
    n_cmp++; if (obs !== {HIT, 20'h0A456}) begin n_err++; $display("FAIL b2b_first: got %h want %h", obs, {HIT, 20'h0A456}); end
    @(negedge clk_i);
    obs = rsp_vec();
    req_valid_i = 1'b0;
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL b2b_second: got %h want %h", obs, {MISS, 20'h0}); end
    @(negedge clk_i);
    obs = rsp_vec();
    n_cmp++; if (obs !== 24'h0) begin n_err++; $display("FAIL b2b_idle: got %h want %h", obs, 24'h0); end
  endtask

  task automatic test_replacement();
    logic [23:0] obs;
    do_inval_all();
    for (int v = 1; v <= 6; v++) do_fill(20'(v), 8'(8'h10 + v), 3'b111);
    do_lookup(32'h0000_1000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL repl_vpn1: got %h want %h", obs, {MISS, 20'h0}); end
    do_lookup(32'h0000_2000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL repl_vpn2: got %h want %h", obs, {MISS, 20'h0}); end
    do_lookup(32'h0000_3456, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h13456}) begin n_err++; $display("FAIL repl_vpn3: got %h want %h", obs, {HIT, 20'h13456}); end
    do_lookup(32'h0000_5000, 3'b100, obs);
    n_cmp++; if (obs !== {HIT, 20'h15000}) begin n_err++; $display("FAIL repl_vpn5: got %h want %h", obs, {HIT, 20'h15000}); end
  endtask

  task automatic test_refill_inval();
    logic [23:0] obs;
    do_fill(20'h00003, 8'h33, 3'b001);
    do_lookup(32'h0000_3ABC, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h33ABC}) begin n_err++; $display("FAIL refill_vpn3: got %h want %h", obs, {HIT, 20'h33ABC}); end
    do_inval_page(20'h00003);
    do_lookup(32'h0000_3ABC, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL inval_vpn3: got %h want %h", obs, {MISS, 20'h0}); end
    do_fill(20'h00007, 8'h17, 3'b001);
    do_fill(20'h00009, 8'h19, 3'b001);
    // freed slot took VPN 7; the pointer (still 2) then evicts it for VPN 9
    do_lookup(32'h0000_7000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL ptr_evict_vpn7: got %h want %h", obs, {MISS, 20'h0}); end
    do_lookup(32'h0000_4000, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h14000}) begin n_err++; $display("FAIL ptr_keep_vpn4: got %h want %h", obs, {HIT, 20'h14000}); end
    do_fill(20'h0000A, 8'h1A, 3'b001);
    do_fill(20'h0000B, 8'h1B, 3'b001);
    do_lookup(32'h0000_5000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL wrap_vpn5: got %h want %h", obs, {MISS, 20'h0}); end
    do_lookup(32'h0000_6000, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h16000}) begin n_err++; $display("FAIL wrap_vpn6: got %h want %h", obs, {HIT, 20'h16000}); end
    do_lookup(32'h0000_B001, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h1B001}) begin n_err++; $display("FAIL wrap_vpnB: got %h want %h", obs, {HIT, 20'h1B001}); end
  endtask

  task automatic test_update_priority();
    logic [23:0] obs;
    @(negedge clk_i);
    fill_i = 1'b1; fill_vpn_i = 20'h0000C; fill_ppn_i = 8'h1C; fill_perm_i = 3'b111;
    inval_all_i = 1'b1; req_valid_i = 1'b1; req_vaddr_i = 32'h0000_6000; req_access_i = 3'b001;
    #1;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL prio_ready: got %b want 0", req_ready_o); end
    @(negedge clk_i);
    fill_i = 1'b0; inval_all_i = 1'b0; req_valid_i = 1'b0;
    obs = rsp_vec();
    n_cmp++; if (obs !== 24'h0) begin n_err++; $display("FAIL prio_no_rsp: got %h want %h", obs, 24'h0); end
    do_lookup(32'h0000_6000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL prio_empty_vpn6: got %h want %h", obs, {MISS, 20'h0}); end
    do_lookup(32'h0000_C000, 3'b001, obs);
    n_cmp++; if (obs !== {MISS, 20'h0}) begin n_err++; $display("FAIL prio_fill_dropped: got %h want %h", obs, {MISS, 20'h0}); end
    // fill outranks a same-cycle page invalidation of the same VPN
    @(negedge clk_i);
    fill_i = 1'b1; fill_vpn_i = 20'h0000D; fill_ppn_i = 8'h1D; fill_perm_i = 3'b001;
    inval_page_i = 1'b1; inval_vpn_i = 20'h0000D;
    @(negedge clk_i);
    fill_i = 1'b0; inval_page_i = 1'b0;
    do_lookup(32'h0000_D010, 3'b001, obs);
    n_cmp++; if (obs !== {HIT, 20'h1D010}) begin n_err++; $display("FAIL prio_fill_over_page: got %h want %h", obs, {HIT, 20'h1D010}); end
  endtask

`ifdef SEGRE_TLB_PERF_CNT_EN
  task automatic test_perf();
    logic [23:0] obs;
    @(negedge clk_i); perf_clr_i = 1'b1;
    @(negedge clk_i); perf_clr_i = 1'b0;
    for (int k = 0; k < 3; k++) do_lookup(32'h0000_D000, 3'b001, obs);
    for (int k = 0; k < 2; k++) do_lookup(32'h0000_F000, 3'b001, obs);
    n_cmp++; if (hit_cnt_o !== 32'd3) begin n_err++; $display("FAIL perf_hit: got %0d want 3", hit_cnt_o); end
    n_cmp++; if (miss_cnt_o !== 32'd2) begin n_err++; $display("FAIL perf_miss: got %0d want 2", miss_cnt_o); end
    @(negedge clk_i);
    req_valid_i = 1'b1; req_vaddr_i = 32'h0000_D000; req_access_i = 3'b001; perf_clr_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0; perf_clr_i = 1'b0;
    n_cmp++; if (rsp_hit_o !== 1'b1) begin n_err++; $display("FAIL perf_clr_rsp: got %b want 1", rsp_hit_o); end
    n_cmp++; if ({hit_cnt_o, miss_cnt_o} !== 64'h0) begin n_err++; $display("FAIL perf_clr: got %0d/%0d want 0/0", hit_cnt_o, miss_cnt_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_hit_perm();
    test_back_to_back();
    test_replacement();
    test_refill_inval();
    test_update_priority();
`ifdef SEGRE_TLB_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
